// File: rtl/pkt_pad_seq.sv
// pkt_pad_seq: streaming message padder.
//
// Passes a message of W-bit words straight through, then appends one pad
// word (MSB set), as many zero words as needed, and one length word (the
// message length in bits) so the whole output is a multiple of BLK words.
//
// Handshake: a word moves on a port exactly when its valid and ready are
// both high on a rising clk edge (in_valid & in_ready, out_valid &
// out_ready). Valid never waits on ready. Nothing in the block changes
// state unless an output word moves.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   in_data/in_valid/   message word stream from the source; in_last marks
//   in_last/in_ready    the final word of a message
//   out_data/out_kind/  padded stream to the sink; out_kind is 0=data,
//   out_valid/out_last/ 1=pad, 2=zero, 3=length; out_last marks the
//   out_ready           length word
//   dbg_state           current sequencer state, for observation only
module pkt_pad_seq #(
  parameter int W   = 64,
  parameter int BLK = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_kind,
  output logic         out_valid,
  output logic         out_last,
  input  logic         out_ready,
  output logic [1:0]   dbg_state
);

  localparam int PW = $clog2(BLK);

  localparam logic [PW-1:0] POS_LAST   = PW'(BLK - 1);
  localparam logic [PW-1:0] POS_PENULT = PW'(BLK - 2);
  localparam logic [W-1:0]  WORD_BITS  = W'(W);
  localparam logic [W-1:0]  PAD_WORD   = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_DATA = 2'd0,
    S_PAD  = 2'd1,
    S_ZERO = 2'd2,
    S_LEN  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [W-1:0]  bitlen_q, bitlen_d;

  logic          out_xfer;
  logic [PW-1:0] pos_inc;

  // Explicit wrap so non-power-of-two BLK also works.
  assign pos_inc = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;

  // Output decode and next-state logic. DATA is a zero-latency
  // pass-through, so the outputs depend on state and on the live inputs.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b1;
    out_data  = '0;
    out_kind  = 2'd0;
    out_last  = 1'b0;
    state_d   = state_q;
    pos_d     = pos_q;
    bitlen_d  = bitlen_q;

    case (state_q)
      S_DATA: begin
        in_ready  = out_ready;
        out_valid = in_valid;
        out_data  = in_data;
        out_kind  = 2'd0;
      end
      S_PAD: begin
        out_data = PAD_WORD;
        out_kind = 2'd1;
      end
      S_ZERO: begin
        out_data = '0;
        out_kind = 2'd2;
      end
      S_LEN: begin
        out_data = bitlen_q;
        out_kind = 2'd3;
        out_last = 1'b1;
      end
      default: ;
    endcase

    out_xfer = out_valid & out_ready;

    if (out_xfer) begin
      case (state_q)
        S_DATA: begin
          bitlen_d = bitlen_q + WORD_BITS;   // wraps modulo 2^W
          pos_d    = pos_inc;
          if (in_last) state_d = S_PAD;
        end
        S_PAD: begin
          pos_d = pos_inc;
          // Pad in the last slot still goes to ZERO: a whole extra block
          // is needed to carry the length word.
          state_d = (pos_q == POS_PENULT) ? S_LEN : S_ZERO;
        end
        S_ZERO: begin
          pos_d = pos_inc;
          if (pos_q == POS_PENULT) state_d = S_LEN;
        end
        S_LEN: begin
          pos_d    = '0;
          bitlen_d = '0;
          state_d  = S_DATA;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_DATA;
      pos_q    <= '0;
      bitlen_q <= '0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      bitlen_q <= bitlen_d;
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_pkt_pad_seq.sv
// Testbench for pkt_pad_seq (W=64, BLK=4).
// Directed table of message lengths with fixed expected word counts and
// length values, hand-written backpressure and reset sequences, then
// random messages under random backpressure checked by a scoreboard fed
// from a message-level padding model.
module tb_pkt_pad_seq;

  localparam int W   = 64;
  localparam int BLK = 4;
  localparam int EW  = W + 3;   // {last, kind[1:0], data}

  logic         clk;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic [1:0]   out_kind;
  logic         out_valid;
  logic         out_last;
  logic         out_ready;
  logic [1:0]   dbg_state;

  pkt_pad_seq #(.W(W), .BLK(BLK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_kind  (out_kind),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            out_cnt = 0;
  logic [W-1:0]  last_len = '0;
  bit            mon_phase = 1'b1;
  bit            rand_ready = 1'b0;
  int            ready_pct = 70;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the padded image of an n-word message, from the
  // block-size arithmetic alone.
  task automatic model_push(input int n, input logic [W-1:0] words[16]);
    int zeros;
    logic [W-1:0] len;
    for (int i = 0; i < n; i++) exp_q.push_back({1'b0, 2'd0, words[i]});
    exp_q.push_back({1'b0, 2'd1, 1'b1, {(W-1){1'b0}}});
    zeros = (BLK - ((n + 2) % BLK)) % BLK;
    for (int i = 0; i < zeros; i++) exp_q.push_back({1'b0, 2'd2, {W{1'b0}}});
    len = W'(n * W);
    exp_q.push_back({1'b1, 2'd3, len});
  endtask

  // Monitor: handshake-phase checks plus in-order compare of every
  // output transfer, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (mon_phase) begin
        if (exp_q.size() == 0 || exp_q[0][W+1:W] == 2'd0) begin
          chk("data_in_ready", 128'(in_ready), 128'(out_ready));
          chk("data_out_valid", 128'(out_valid), 128'(in_valid));
        end else begin
          chk("pad_out_valid", 128'(out_valid), 128'd1);
          chk("pad_in_ready", 128'(in_ready), 128'd0);
        end
      end
      if (out_valid && out_ready) begin
        out_cnt++;
        if (out_last) last_len = out_data;
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 128'({out_last, out_kind, out_data}), 128'h0);
        end else begin
          chk("out_word", 128'({out_last, out_kind, out_data}), 128'(exp_q.pop_front()));
        end
      end
    end
  end

  // Random sink backpressure when enabled.
  always @(posedge clk) begin
    if (rand_ready) begin
      #1 out_ready = ($urandom_range(99) < 32'(ready_pct));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_msg(input int n, input bit gaps);
    logic [W-1:0] words[16];
    bit x;
    bit done;
    for (int i = 0; i < 16; i++) words[i] = {$urandom, $urandom};
    model_push(n, words);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = words[i];
      in_last  = (i == n - 1);
      done = 1'b0;
      for (int t = 0; t < 300 && !done; t++) begin
        @(negedge clk);
        x = in_ready;
        @(posedge clk);
        #1;
        done = x;
      end
      if (!done) chk("in_xfer_timeout", 128'd0, 128'd1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (gaps && $urandom_range(3) == 0) begin
        int g = $urandom_range(1, 2);
        for (int k = 0; k < g; k++) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 128'(exp_q.size()), 128'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int           n;
    int           exp_words;
    logic [W-1:0] exp_len;
  } vec_t;

  vec_t vecs[5];

  initial begin
    rst = 1'b1;
    in_data = '0;
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    // Reset state follows the DATA rules.
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_kind", 128'(out_kind), 128'd0);
    chk("rst_out_last", 128'(out_last), 128'd0);
    in_data = 64'hDEAD_BEEF_0123_4567;
    in_valid = 1'b1;
    #1;
    chk("rst_passthru_data", 128'(out_data), 128'h0000_0000_0000_0000_DEAD_BEEF_0123_4567);
    chk("rst_passthru_valid", 128'(out_valid), 128'd1);
    out_ready = 1'b0;
    #1;
    chk("rst_in_ready_low", 128'(in_ready), 128'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    rst = 1'b0;
    #1;

    vecs[0] = '{1, 4,  64'h40};
    vecs[1] = '{2, 4,  64'h80};
    vecs[2] = '{3, 8,  64'hC0};
    vecs[3] = '{4, 8,  64'h100};
    vecs[4] = '{5, 8,  64'h140};

    for (int v = 0; v < 5; v++) begin
      out_cnt = 0;
      send_msg(vecs[v].n, 1'b0);
      drain();
      chk($sformatf("tbl%0d_words", v), 128'(out_cnt), 128'(vecs[v].exp_words));
      chk($sformatf("tbl%0d_len", v), 128'(last_len), 128'(vecs[v].exp_len));
    end

    // Backpressure while in ZERO after a 1-word message.
    begin
      logic [W-1:0] words[16];
      words[0] = 64'h1111_2222_3333_4444;
      for (int i = 1; i < 16; i++) words[i] = '0;
      model_push(1, words);
      in_valid = 1'b1;
      in_data = words[0];
      in_last = 1'b1;
      step();                       // D0 accepted
      in_valid = 1'b0;
      in_last = 1'b0;
      step();                       // pad accepted, now ZERO
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        chk("bp_valid", 128'(out_valid), 128'd1);
        chk("bp_data", 128'(out_data), 128'd0);
        chk("bp_kind", 128'(out_kind), 128'd2);
        chk("bp_in_ready", 128'(in_ready), 128'd0);
        step();
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_zero_kind", 128'(out_kind), 128'd2);
      step();
      @(negedge clk);
      chk("bp_len_kind", 128'(out_kind), 128'd3);
      chk("bp_len_data", 128'(out_data), 128'h40);
      chk("bp_len_last", 128'(out_last), 128'd1);
      step();
      chk("bp_drained", 128'(exp_q.size()), 128'd0);
    end

    // Reset in the middle of ZERO abandons the message.
    begin
      logic [W-1:0] words[16];
      words[0] = 64'hAAAA_5555_AAAA_5555;
      for (int i = 1; i < 16; i++) words[i] = '0;
      exp_q.push_back({1'b0, 2'd0, words[0]});
      exp_q.push_back({1'b0, 2'd1, 1'b1, {(W-1){1'b0}}});
      in_valid = 1'b1;
      in_data = words[0];
      in_last = 1'b1;
      step();
      in_valid = 1'b0;
      in_last = 1'b0;
      mon_phase = 1'b0;
      step();                       // pad accepted, now ZERO
      chk("rst_mid_sb_empty", 128'(exp_q.size()), 128'd0);
      rst = 1'b1;
      out_ready = 1'b0;
      step();
      rst = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("rst_mid_in_ready", 128'(in_ready), 128'd1);
      chk("rst_mid_out_valid", 128'(out_valid), 128'd0);
      chk("rst_mid_kind", 128'(out_kind), 128'd0);
      mon_phase = 1'b1;
      step();
      out_cnt = 0;
      send_msg(1, 1'b0);
      drain();
      chk("rst_mid_words", 128'(out_cnt), 128'd4);
      chk("rst_mid_len", 128'(last_len), 128'h40);
    end

    // Random messages under random backpressure.
    rand_ready = 1'b1;
    for (int m = 0; m < 40; m++) begin
      ready_pct = $urandom_range(30, 100);
      send_msg($urandom_range(1, 11), 1'b1);
    end
    drain();
    rand_ready = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global guard against a hang.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
